sm83_irq_ctl: RTL and testbench
===============================

# sm83_irq_ctl

Interrupt controller sitting directly upstream of the sm83 core. It latches peripheral interrupt requests into the IF register, masks them with the IE register, and drives the core's `irq` vector. It clears IF bits when the core returns `iack`. IF and IE are exposed to software on the CPU data bus at their memory-mapped addresses.

## Interface
Parameters:
- `NUM_SRC`, 5: number of peripheral request lines (bit 0 = VBlank, 1 = STAT, 2 = timer, 3 = serial, 4 = joypad); legal range 1..8.
- `IF_ADR`, 16'hff0f: address of the IF register.
- `IE_ADR`, 16'hffff: address of the IE register.

Ports:
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `adr`, in, 16: CPU address bus.
- `din`, in, 8: CPU write data.
- `wr`, in, 1: write strobe; one-cycle pulse per CPU write.
- `rd`, in, 1: read enable.
- `dout`, out, 8: read data.
- `sel`, out, 1: high when `rd` is high and `adr` matches IF_ADR or IE_ADR; the bus mux uses it to select `dout`.
- `req`, in, NUM_SRC: level requests from peripherals in the `clk` domain; each rising edge requests one interrupt.
- `irq`, out, 8: pending-and-enabled vector to the core; bits ≥ NUM_SRC are tied 0.
- `iack`, in, 8: one-hot acknowledge from the core; it is either zero or a single pulse of one cycle.
- `wake`, out, 1: high when any bit of IF & IE is set, regardless of IME; used to exit HALT/STOP.

## Operation
- State:
  - `req_q[NUM_SRC]` holds last cycle's `req`.
  - `if_q[NUM_SRC]` holds pending flags.
  - `ie_q[8]` holds enables; all 8 IE bits are stored.
- Edge detect: `rise = req & ~req_q`, evaluated every cycle.
- IF next-state, per bit i, in priority order:
  1. `rise[i]` gives 1.
  2. Otherwise, a write with `adr==IF_ADR` gives `din[i]`.
  3. Otherwise, `iack[i]` gives 0.
  4. Otherwise, the bit holds.
- The request edge always wins over a same-cycle software write or ack, so no edge is ever lost.
- IE next-state: a write with `adr==IE_ADR` gives `din`; otherwise the register holds.
- An IF write and an ack on the same bit in the same cycle: the write wins.
- `iack` bits ≥ NUM_SRC are ignored.
- `irq[i] = if_q[i] & ie_q[i]` for i < NUM_SRC.
  - Combinational from registers only; there is no path from `req`, `din` or `iack` to `irq`.
- `wake = |irq`.
- Reads:
  - IF reads as {1 for bits 7..NUM_SRC, if_q}.
  - IE reads as `ie_q`.
  - `dout` is combinational from `adr` and the registers.
  - `dout` = 8'hff when `sel` is low.
- Software writes setting IF bits raise `irq` exactly like hardware requests.
- No internal priority encoding; the core selects the lowest set bit.

## Timing
- Reset (asynchronous): `if_q` = 0, `ie_q` = 0, and `req_q` = all ones.
  - Consequently, a request held high through reset does not fire until it falls and rises again.
- Output reset values: `irq` = 0, `wake` = 0, `sel` = 0, `dout` = 8'hff.
- Request latency: `req[i]` goes 0→1 before edge N, `if_q[i]` is set at edge N, and `irq[i]` is high from edge N onward, provided IE bit i is set.
- A request held high sets IF once; re-triggering requires the line to be low for at least one sampled cycle.
- Ack latency: `iack[i]` is high before edge N and `irq[i]` falls at edge N.
- Register writes take effect at the edge that samples `wr`; a read in the following cycle returns the new value.
- Reset asserted mid-operation clears all state immediately, without waiting for `clk`; pending requests are lost.
- `rd` and `wr` both high in one cycle is legal: `dout` shows the pre-write value.

## Test plan
- Reset: assert `reset` with `req`=5'h1f. Required response:
  - `irq`=0, IF reads 8'he0, IE reads 8'h00.
  - After reset release with `req` held at 5'h1f, IF stays 8'he0.
- Edge latch: write IE=8'h1f, then pulse `req[2]` for one cycle. Required response:
  - `irq`=8'h04 starting at the next edge and staying high after `req` falls; `wake`=1.
  - `iack`=8'h04 for one cycle clears it, giving `irq`=0 and IF reads 8'he0.
- Masking: IE=8'h01 with a rise on `req[3]`. Required response:
  - IF reads 8'he8, `irq`=0, `wake`=0.
  - Writing IE=8'h08 gives `irq`=8'h08 at the next edge.
- Collision: in the same cycle, a rise on `req[0]`, a write IF=8'h00, and `iack`=8'h01. Required response: IF reads 8'he1 afterwards.
- Software set/clear: write IF=8'hff with IE=8'hff. Required response:
  - `irq`=8'h1f and IE reads 8'hff.
  - Writing IF=8'h00 gives `irq`=0.
  - A read of an unmapped address (16'hff10) gives `sel`=0 and `dout`=8'hff.
- Mid-operation reset: with IF=8'hff and IE=8'hff, pulse `reset` between clock edges. Required response: `irq` drops to 0 before the next `clk` edge.

Source files
------------

// File: rtl/sm83_irq_ctl_if.sv
// Bus and interrupt signals between the CPU side and the interrupt controller.
// The master modport is the CPU/bus side; the slave modport is the controller.
interface sm83_irq_ctl_if #(
  parameter int NUM_SRC = 5
);
  logic [15:0]        adr;
  logic [7:0]         din;
  logic               wr;
  logic               rd;
  logic [7:0]         dout;
  logic               sel;
  logic [NUM_SRC-1:0] req;
  logic [7:0]         irq;
  logic [7:0]         iack;
  logic               wake;

  modport master (
    output adr, din, wr, rd, req, iack,
    input  dout, sel, irq, wake
  );

  modport slave (
    input  adr, din, wr, rd, req, iack,
    output dout, sel, irq, wake
  );
endinterface

// File: rtl/sm83_irq_ctl.sv
// Interrupt controller for the sm83 core.
// Peripheral request edges are latched into IF and masked by IE to form the
// irq vector. The core clears IF bits with a one-hot iack. Both registers are
// readable and writable over the CPU bus.
module sm83_irq_ctl #(
  parameter int          NUM_SRC = 5,
  parameter logic [15:0] IF_ADR  = 16'hff0f,
  parameter logic [15:0] IE_ADR  = 16'hffff
) (
  input  logic           clk,
  input  logic           reset,
  sm83_irq_ctl_if.slave  bus
);

  logic [NUM_SRC-1:0] req_reg;
  logic [NUM_SRC-1:0] if_reg;
  logic [NUM_SRC-1:0] if_next;
  logic [NUM_SRC-1:0] rise;
  logic [7:0]         ie_reg;
  logic [7:0]         ie_next;
  logic [7:0]         if_rd;
  logic [7:0]         irq_vec;
  logic               hit_if;
  logic               hit_ie;
  logic               wr_if;
  logic               wr_ie;

  assign hit_if = (bus.adr == IF_ADR);
  assign hit_ie = (bus.adr == IE_ADR);
  assign wr_if  = bus.wr && hit_if;
  assign wr_ie  = bus.wr && hit_ie;

  // A request line held high through reset must not fire, so the history resets to ones.
  assign rise = bus.req & ~req_reg;

  // Per-bit IF update: a request edge beats a software write, which beats an ack.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_if_bit
      always_comb begin
        if (rise[gi]) begin
          if_next[gi] = 1'b1;
        end else if (wr_if) begin
          if_next[gi] = bus.din[gi];
        end else if (bus.iack[gi]) begin
          if_next[gi] = 1'b0;
        end else begin
          if_next[gi] = if_reg[gi];
        end
      end
    end
  endgenerate

  // IE takes the whole written byte, even bits with no source behind them.
  always_comb begin
    ie_next = ie_reg;
    if (wr_ie) begin
      ie_next = bus.din;
    end
  end

  // State registers; reset clears everything without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_reg <= '1;
      if_reg  <= '0;
      ie_reg  <= '0;
    end else begin
      req_reg <= bus.req;
      if_reg  <= if_next;
      ie_reg  <= ie_next;
    end
  end

  // Build the 8-bit irq vector and IF read image; unimplemented IF bits read as 1.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_byte_bit
      if (gi < NUM_SRC) begin : g_src
        assign irq_vec[gi] = if_reg[gi] & ie_reg[gi];
        assign if_rd[gi]   = if_reg[gi];
      end else begin : g_nosrc
        assign irq_vec[gi] = 1'b0;
        assign if_rd[gi]   = 1'b1;
      end
    end
  endgenerate

  // Ack bits above the implemented sources have no effect.
  generate
    if (NUM_SRC < 8) begin : g_unused_iack
      logic unused_iack;
      assign unused_iack = ^bus.iack[7:NUM_SRC];
    end
  endgenerate

  assign bus.irq  = irq_vec;
  assign bus.wake = |irq_vec;

  // Read path is purely combinational, so a same-cycle write shows the old value.
  always_comb begin
    bus.sel  = 1'b0;
    bus.dout = 8'hff;
    if (bus.rd && hit_if) begin
      bus.sel  = 1'b1;
      bus.dout = if_rd;
    end else if (bus.rd && hit_ie) begin
      bus.sel  = 1'b1;
      bus.dout = ie_reg;
    end
  end

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Self-checking bench for sm83_irq_ctl: a table of per-cycle vectors plus
// hand-written reset sequences.
module tb_sm83_irq_ctl;

  localparam logic [15:0] A_IF = 16'hff0f;
  localparam logic [15:0] A_IE = 16'hffff;
  localparam logic [15:0] A_NO = 16'hff10;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] adr;
    logic [7:0]  din;
    logic [4:0]  req;
    logic [7:0]  iack;
    logic [7:0]  exp_irq;
    logic        exp_wake;
    logic        exp_sel;
    logic [7:0]  exp_dout;
  } vec_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  vec_t vecs[$];

  sm83_irq_ctl_if #(.NUM_SRC(5)) bus ();

  sm83_irq_ctl #(
    .NUM_SRC(5),
    .IF_ADR (A_IF),
    .IE_ADR (A_IE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h, required %02h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic [15:0] adr,
                     input logic [7:0] din, input logic [4:0] req, input logic [7:0] iack,
                     input logic [7:0] e_irq, input logic e_wake, input logic e_sel,
                     input logic [7:0] e_dout);
    vec_t v;
    v.wr = wr; v.rd = rd; v.adr = adr; v.din = din; v.req = req; v.iack = iack;
    v.exp_irq = e_irq; v.exp_wake = e_wake; v.exp_sel = e_sel; v.exp_dout = e_dout;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [15:0] adr,
                       input logic [7:0] din, input logic [4:0] req, input logic [7:0] iack);
    bus.wr = wr; bus.rd = rd; bus.adr = adr; bus.din = din; bus.req = req; bus.iack = iack;
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // Expected values are the outputs seen just before the edge that samples
    // the vector's inputs (state reflects all earlier vectors).
    //   wr  rd  adr   din    req    iack   irq    wake sel  dout
    add(0, 1, A_IF, 8'h00, 5'h1f, 8'h00, 8'h00, 0, 1, 8'he0); // 0 held req after reset
    add(1, 0, A_IE, 8'h1f, 5'h1f, 8'h00, 8'h00, 0, 0, 8'hff); // 1 IE=1f, no rd -> no sel
    add(0, 1, A_IF, 8'h00, 5'h1f, 8'h00, 8'h00, 0, 1, 8'he0); // 2 IF still e0
    add(0, 0, A_IF, 8'h00, 5'h00, 8'h00, 8'h00, 0, 0, 8'hff); // 3 req low
    add(0, 0, A_IF, 8'h00, 5'h04, 8'h00, 8'h00, 0, 0, 8'hff); // 4 req[2] pulse
    add(0, 1, A_IF, 8'h00, 5'h00, 8'h00, 8'h04, 1, 1, 8'he4); // 5 latched
    add(0, 0, A_IF, 8'h00, 5'h00, 8'h00, 8'h04, 1, 0, 8'hff); // 6 stays after fall
    add(0, 0, A_IF, 8'h00, 5'h00, 8'h04, 8'h04, 1, 0, 8'hff); // 7 ack
    add(0, 1, A_IF, 8'h00, 5'h00, 8'h00, 8'h00, 0, 1, 8'he0); // 8 cleared
    add(1, 0, A_IE, 8'h01, 5'h00, 8'h00, 8'h00, 0, 0, 8'hff); // 9 IE=01
    add(0, 0, A_IF, 8'h00, 5'h08, 8'h00, 8'h00, 0, 0, 8'hff); // 10 rise req[3]
    add(0, 1, A_IF, 8'h00, 5'h08, 8'h00, 8'h00, 0, 1, 8'he8); // 11 masked
    add(1, 0, A_IE, 8'h08, 5'h08, 8'h00, 8'h00, 0, 0, 8'hff); // 12 IE=08
    add(0, 1, A_IE, 8'h00, 5'h00, 8'h00, 8'h08, 1, 1, 8'h08); // 13 unmasked
    add(0, 0, A_IF, 8'h00, 5'h00, 8'h08, 8'h08, 1, 0, 8'hff); // 14 ack
    add(1, 0, A_IF, 8'h00, 5'h01, 8'h01, 8'h00, 0, 0, 8'hff); // 15 collision
    add(0, 1, A_IF, 8'h00, 5'h00, 8'h00, 8'h00, 0, 1, 8'he1); // 16 edge won
    add(1, 0, A_IF, 8'h02, 5'h00, 8'h02, 8'h00, 0, 0, 8'hff); // 17 write beats ack
    add(0, 1, A_IF, 8'h00, 5'h00, 8'h00, 8'h00, 0, 1, 8'he2); // 18
    add(1, 1, A_IF, 8'h00, 5'h00, 8'h00, 8'h00, 0, 1, 8'he2); // 19 rd+wr shows old
    add(0, 1, A_IF, 8'h00, 5'h00, 8'h00, 8'h00, 0, 1, 8'he0); // 20 new value
    add(1, 0, A_IE, 8'hff, 5'h00, 8'h00, 8'h00, 0, 0, 8'hff); // 21 IE=ff
    add(1, 0, A_IF, 8'hff, 5'h00, 8'h00, 8'h00, 0, 0, 8'hff); // 22 IF=ff
    add(0, 1, A_IE, 8'h00, 5'h00, 8'h00, 8'h1f, 1, 1, 8'hff); // 23 IE reads ff
    add(0, 1, A_IF, 8'h00, 5'h00, 8'h00, 8'h1f, 1, 1, 8'hff); // 24 IF reads ff
    add(0, 1, A_NO, 8'h00, 5'h00, 8'h00, 8'h1f, 1, 0, 8'hff); // 25 unmapped
    add(1, 0, A_IF, 8'h00, 5'h00, 8'h00, 8'h1f, 1, 0, 8'hff); // 26 IF=00
    add(0, 1, A_IF, 8'h00, 5'h00, 8'h00, 8'h00, 0, 1, 8'he0); // 27 cleared
    add(1, 0, A_IF, 8'h1f, 5'h00, 8'h00, 8'h00, 0, 0, 8'hff); // 28 IF=1f
    add(0, 0, A_IF, 8'h00, 5'h00, 8'h80, 8'h1f, 1, 0, 8'hff); // 29 ack bit 7 ignored
    add(0, 1, A_IF, 8'h00, 5'h00, 8'h00, 8'h1f, 1, 1, 8'hff); // 30 still set

    // Reset with all requests held high.
    reset = 1'b1;
    drive(0, 0, A_IF, 8'h00, 5'h1f, 8'h00);
    repeat (2) @(negedge clk);
    #1;
    check("rst_irq", bus.irq, 8'h00);
    check("rst_wake", {7'd0, bus.wake}, 8'h00);
    check("rst_sel", {7'd0, bus.sel}, 8'h00);
    check("rst_dout", bus.dout, 8'hff);
    bus.rd = 1'b1;
    #1;
    check("rst_if_rd", bus.dout, 8'he0);
    bus.adr = A_IE;
    #1;
    check("rst_ie_rd", bus.dout, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors: drive at the falling edge, sample 1 ns later.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].adr, vecs[i].din, vecs[i].req, vecs[i].iack);
      #1;
      check($sformatf("v%0d_irq", i), bus.irq, vecs[i].exp_irq);
      check($sformatf("v%0d_wake", i), {7'd0, bus.wake}, {7'd0, vecs[i].exp_wake});
      check($sformatf("v%0d_sel", i), {7'd0, bus.sel}, {7'd0, vecs[i].exp_sel});
      check($sformatf("v%0d_dout", i), bus.dout, vecs[i].exp_dout);
      $display("[TB] vec %0d adr=%04h wr=%0b rd=%0b req=%02h iack=%02h -> irq=%02h dout=%02h",
               i, vecs[i].adr, vecs[i].wr, vecs[i].rd, vecs[i].req, vecs[i].iack, bus.irq, bus.dout);
      @(negedge clk);
    end

    // Mid-operation reset between edges: IF=1f, IE=ff at this point.
    drive(0, 0, A_IF, 8'h00, 5'h00, 8'h00);
    #1;
    check("pre_pulse_irq", bus.irq, 8'h1f);
    #1;
    reset = 1'b1;
    #1;
    check("pulse_irq", bus.irq, 8'h00);
    check("pulse_wake", {7'd0, bus.wake}, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    bus.rd = 1'b1;
    #1;
    check("post_pulse_if", bus.dout, 8'he0);
    bus.adr = A_IE;
    #1;
    check("post_pulse_ie", bus.dout, 8'h00);
    $display("[TB] mid-operation reset sequence done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
